// File: rtl/if_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_stage_pkg
//  Brief    : Shared widths, stall encodings and IF state encoding for fetch.
//  Revision : 1.0  initial release
// ============================================================================
package if_fetch_stage_pkg;

    localparam int          STALL_WD     = 6;
    localparam int          BR_WD        = 33;
    localparam int          IF_TO_ID_WD  = 33;
    localparam logic        STOP         = 1'b1;
    localparam logic        NO_STOP      = 1'b0;
    localparam logic [31:0] PC_RESET_VEC = 32'hBFBF_FFFC;

    typedef enum logic [1:0] {
        IF_BOOT = 2'd0,
        IF_RUN  = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

endpackage : if_fetch_stage_pkg
`default_nettype wire

// File: rtl/if_redirect_buf.sv
`default_nettype none
// ============================================================================
//  Module   : if_redirect_buf
//  Brief    : Holds a redirect deferred by a stall; newest live redirect wins.
//  Revision : 1.0  initial release
// ============================================================================
module if_redirect_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_addr,
    input  logic        live_e,
    input  logic [31:0] live_addr,
    output logic        pend_v,
    output logic [31:0] pend_addr,
    output logic [31:0] sel_addr
);

    logic        r_pend_v;
    logic [31:0] r_pend_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend_v    <= 1'b0;
            r_pend_addr <= 32'h0;
        end else if (load) begin
            r_pend_v    <= 1'b1;
            r_pend_addr <= load_addr;
        end else if (clear) begin
            r_pend_v    <= 1'b0;
        end
    end

    assign pend_v    = r_pend_v;
    assign pend_addr = r_pend_addr;
    assign sel_addr  = live_e ? live_addr : r_pend_addr;

endmodule : if_redirect_buf
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_stage
//  Brief    : IF stage: PC register, instruction SRAM request, deferred redirect.
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = PC_RESET_VEC,
    parameter int          CNT_WD    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_WD-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    output logic [CNT_WD-1:0]      fetch_cnt,
    output logic                   redirect_pending
);

    localparam logic [31:0]       c_boot_pc = RESET_VEC + 32'd4;
    localparam logic [CNT_WD-1:0] c_cnt_one = {{(CNT_WD-1){1'b0}}, 1'b1};

    if_state_e         r_state;
    if_state_e         w_state_nxt;
    logic [31:0]       r_pc;
    logic              r_ce;
    logic [CNT_WD-1:0] r_cnt;

    logic        w_stop;
    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_nxt;
    logic        w_pc_we;
    logic        w_cnt_inc;
    logic        w_load;
    logic        w_clear;
    logic [31:0] w_fetch_addr;
    logic        w_pend_v;
    logic [31:0] w_pend_addr;
    logic [31:0] w_sel_addr;
    logic        w_stall_unused;

    assign w_stop         = (stall[0] == STOP);
    assign w_br_e         = br_bus[32];
    assign w_br_addr      = br_bus[31:0];
    assign w_next_pc      = w_br_e ? w_br_addr : (r_pc + 32'd4);
    assign w_stall_unused = ^stall[STALL_WD-1:1];

    if_redirect_buf u_redirect_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .clear     (w_clear),
        .load_addr (w_br_addr),
        .live_e    (w_br_e),
        .live_addr (w_br_addr),
        .pend_v    (w_pend_v),
        .pend_addr (w_pend_addr),
        .sel_addr  (w_sel_addr)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_pc_we      = 1'b0;
        w_cnt_inc    = 1'b0;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_fetch_addr = r_pc;
        case (r_state)
            IF_BOOT: begin
                w_state_nxt  = IF_RUN;
                w_pc_nxt     = c_boot_pc;
                w_pc_we      = 1'b1;
                w_fetch_addr = c_boot_pc;
            end
            IF_RUN: begin
                if (!w_stop) begin
                    w_pc_nxt     = w_next_pc;
                    w_pc_we      = 1'b1;
                    w_cnt_inc    = 1'b1;
                    w_fetch_addr = w_next_pc;
                end else if (w_br_e) begin
                    w_load      = 1'b1;
                    w_state_nxt = IF_HOLD;
                end
            end
            IF_HOLD: begin
                // While stalled, a newer redirect replaces the held one.
                if (w_stop) begin
                    w_load = w_br_e;
                end else begin
                    w_pc_nxt     = w_sel_addr;
                    w_pc_we      = 1'b1;
                    w_cnt_inc    = 1'b1;
                    w_clear      = 1'b1;
                    w_fetch_addr = w_sel_addr;
                    w_state_nxt  = IF_RUN;
                end
            end
            default: w_state_nxt = IF_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IF_BOOT;
            r_pc    <= RESET_VEC;
            r_ce    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pc_we)
                r_pc <= w_pc_nxt;
            if (r_state == IF_BOOT)
                r_ce <= 1'b1;
            if (w_cnt_inc)
                r_cnt <= r_cnt + c_cnt_one;
        end
    end

    assign if_to_id_bus     = {r_ce, r_pc};
    assign inst_sram_en     = r_ce;
    assign inst_sram_wen    = 4'b0000;
    assign inst_sram_addr   = w_fetch_addr;
    assign inst_sram_wdata  = 32'h0;
    assign fetch_cnt        = r_cnt;
    assign redirect_pending = w_pend_v;

endmodule : if_fetch_stage
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_stage
//  Brief    : Self-checking bench for if_fetch_stage with a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] fetch_cnt;
    logic        redirect_pending;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [32:0] bus;
        logic        pend;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // reference model state (0 = BOOT, 1 = RUN, 2 = HOLD)
    int          m_st;
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_pv;
    logic [31:0] m_pa;
    logic [31:0] m_cnt;

    if_fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .br_bus           (br_bus),
        .if_to_id_bus     (if_to_id_bus),
        .inst_sram_en     (inst_sram_en),
        .inst_sram_wen    (inst_sram_wen),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wdata  (inst_sram_wdata),
        .fetch_cnt        (fetch_cnt),
        .redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pc = 32'hBFBF_FFFC; m_ce = 1'b0;
        m_pv = 1'b0; m_pa = 32'h0; m_cnt = 32'h0;
    endtask

    function automatic logic [31:0] model_addr(input logic stop, input logic be, input logic [31:0] ba);
        if (m_st == 0)      return 32'hBFC0_0000;
        else if (stop)      return m_pc;
        else if (be)        return ba;
        else if (m_st == 2) return m_pa;
        else                return m_pc + 32'd4;
    endfunction

    task automatic model_clock(input logic r, input logic stop, input logic be, input logic [31:0] ba);
        if (!r) begin
            model_reset();
        end else if (m_st == 0) begin
            m_pc = 32'hBFC0_0000; m_ce = 1'b1; m_st = 1;
        end else if (m_st == 1) begin
            if (!stop) begin
                m_pc  = be ? ba : m_pc + 32'd4;
                m_cnt = m_cnt + 1;
            end else if (be) begin
                m_pv = 1'b1; m_pa = ba; m_st = 2;
            end
        end else begin
            if (stop) begin
                if (be) m_pa = ba;
            end else begin
                m_pc  = be ? ba : m_pa;
                m_pv  = 1'b0;
                m_cnt = m_cnt + 1;
                m_st  = 1;
            end
        end
    endtask

    // One clock: drive at negedge, compare outputs mid-cycle, advance model at posedge.
    task automatic step(input logic r, input logic stop, input logic be, input logic [31:0] ba);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst    = r;
        stall  = {5'b10101, stop};
        br_bus = {be, ba};
        e.addr = model_addr(stop, be, ba);
        e.bus  = {m_ce, m_pc};
        e.pend = m_pv;
        e.cnt  = m_cnt;
        exp_q.push_back(e);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 64'd0, 64'd1);
        end else begin
            got = exp_q.pop_front();
            check("sram_addr", {32'h0, inst_sram_addr}, {32'h0, got.addr});
            check("if_to_id",  {31'h0, if_to_id_bus},   {31'h0, got.bus});
            check("sram_en",   {63'h0, inst_sram_en},   {63'h0, got.bus[32]});
            check("pending",   {63'h0, redirect_pending}, {63'h0, got.pend});
            check("fetch_cnt", {32'h0, fetch_cnt},      {32'h0, got.cnt});
            check("sram_wen",  {60'h0, inst_sram_wen},  64'h0);
            check("sram_wdata",{32'h0, inst_sram_wdata},64'h0);
        end
        @(posedge clk);
        #1;
        model_clock(r, stop, be, ba);
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] exp);
        check(tag, {32'h0, if_to_id_bus[31:0]}, {32'h0, exp});
    endtask

    initial begin
        rst = 1'b0; stall = 6'h0; br_bus = 33'h0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset_pc", {32'h0, if_to_id_bus[31:0]}, {32'h0, 32'hBFBF_FFFC});
        check("reset_ce", {63'h0, if_to_id_bus[32]}, 64'h0);
        check("reset_cnt", {32'h0, fetch_cnt}, 64'h0);

        // boot and sequential fetch
        step(1, 0, 0, 32'h0);
        chk_pc("boot_pc", 32'hBFC0_0000);
        check("boot_ce", {63'h0, if_to_id_bus[32]}, 64'h1);
        step(1, 0, 0, 32'h0);
        chk_pc("seq1_pc", 32'hBFC0_0004);
        step(1, 0, 0, 32'h0);
        chk_pc("seq2_pc", 32'hBFC0_0008);
        check("seq_cnt", {32'h0, fetch_cnt}, 64'd2);

        // unstalled branch
        step(1, 0, 1, 32'hBFC0_0100);
        chk_pc("br_pc", 32'hBFC0_0100);

        // redirect during a 3-cycle stall
        step(1, 1, 1, 32'hBFC0_0200);
        check("hold_pend", {63'h0, redirect_pending}, 64'h1);
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        check("hold_cnt", {32'h0, fetch_cnt}, 64'd3);
        step(1, 0, 0, 32'h0);
        chk_pc("release_pc", 32'hBFC0_0200);
        check("release_pend", {63'h0, redirect_pending}, 64'h0);

        // live redirect on the release cycle beats the held one
        step(1, 1, 1, 32'hBFC0_0400);
        step(1, 0, 1, 32'hBFC0_0300);
        chk_pc("live_wins_pc", 32'hBFC0_0300);
        check("live_wins_pend", {63'h0, redirect_pending}, 64'h0);

        // last writer wins while held
        step(1, 1, 1, 32'hBFC0_0500);
        step(1, 1, 1, 32'hBFC0_0600);
        step(1, 0, 0, 32'h0);
        chk_pc("overwrite_pc", 32'hBFC0_0600);

        // reset while holding
        step(1, 1, 1, 32'hBFC0_0700);
        step(0, 1, 0, 32'h0);
        chk_pc("rst_hold_pc", 32'hBFBF_FFFC);
        check("rst_hold_ce", {63'h0, if_to_id_bus[32]}, 64'h0);
        check("rst_hold_pend", {63'h0, redirect_pending}, 64'h0);
        check("rst_hold_cnt", {32'h0, fetch_cnt}, 64'h0);

        // boot ignores stall, then wrap at top of address space
        step(1, 1, 0, 32'h0);
        chk_pc("boot_stall_pc", 32'hBFC0_0000);
        step(1, 0, 1, 32'hFFFF_FFF8);
        step(1, 0, 0, 32'h0);
        chk_pc("pre_wrap_pc", 32'hFFFF_FFFC);
        step(1, 0, 0, 32'h0);
        chk_pc("wrap_pc", 32'h0000_0000);

        // misaligned redirect passes through
        step(1, 0, 1, 32'h1234_5677);
        chk_pc("misalign_pc", 32'h1234_5677);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), $urandom);
        end
        step(1, 0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_fetch_stage
`default_nettype wire
